// File: rtl/sound_sequencer_if.sv
// rtl/sound_sequencer_if.sv - event/beep signal bundle between game logic and sound_sequencer.
interface sound_sequencer_if;
  logic       frame_pulse;
  logic [3:0] ev_req;
  logic       mute;
  logic       high_beep;
  logic       low_beep;
  logic       busy;
  logic [1:0] cur_ev;
  logic       done;

  modport master (
    output frame_pulse, ev_req, mute,
    input  high_beep, low_beep, busy, cur_ev, done
  );

  modport slave (
    input  frame_pulse, ev_req, mute,
    output high_beep, low_beep, busy, cur_ev, done
  );
endinterface

// File: rtl/sound_sequencer.sv
// rtl/sound_sequencer.sv - frame-timed sound event scheduler with fixed-priority pattern playback.
// Optional feature macro: SOUND_PREEMPT_EN (higher-priority events abandon the playing pattern).
module sound_sequencer #(
  parameter int GAP_FRAMES = 1,
  parameter int DUR_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  sound_sequencer_if.slave  snd
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t           state_q, state_d;
  logic [3:0]       pend_q, pend_d;
  logic [1:0]       ev_q, ev_d;
  logic [1:0]       step_q, step_d;
  logic [DUR_W-1:0] frames_q, frames_d;
  logic             high_q, high_d;
  logic             low_q, low_d;
  logic             done_q, done_d;
  logic [3:0]       clr;
  logic [1:0]       sel;
  logic             preempt;

  // Tone encoding is {high, low}: off=00, low=01, high=10, both=11.
  function automatic logic [1:0] step_tone(input logic [1:0] ev, input logic [1:0] step);
    case ({ev, step})
      4'b00_00: step_tone = 2'b10;
      4'b01_00: step_tone = 2'b01;
      4'b10_00: step_tone = 2'b10;
      4'b10_01: step_tone = 2'b01;
      4'b11_00: step_tone = 2'b01;
      4'b11_01: step_tone = 2'b00;
      4'b11_10: step_tone = 2'b01;
      4'b11_11: step_tone = 2'b11;
      default:  step_tone = 2'b00;
    endcase
  endfunction

  function automatic logic [DUR_W-1:0] step_dur(input logic [1:0] ev, input logic [1:0] step);
    case ({ev, step})
      4'b00_00: step_dur = DUR_W'(2);
      4'b01_00: step_dur = DUR_W'(3);
      4'b10_00: step_dur = DUR_W'(2);
      4'b10_01: step_dur = DUR_W'(2);
      4'b11_00: step_dur = DUR_W'(4);
      4'b11_01: step_dur = DUR_W'(2);
      4'b11_10: step_dur = DUR_W'(4);
      4'b11_11: step_dur = DUR_W'(8);
      default:  step_dur = DUR_W'(1);
    endcase
  endfunction

  function automatic logic [1:0] last_step(input logic [1:0] ev);
    case (ev)
      2'd2:    last_step = 2'd1;
      2'd3:    last_step = 2'd3;
      default: last_step = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] top_idx(input logic [3:0] p);
    if (p[3])      top_idx = 2'd3;
    else if (p[2]) top_idx = 2'd2;
    else if (p[1]) top_idx = 2'd1;
    else           top_idx = 2'd0;
  endfunction

  assign sel = top_idx(pend_q);

`ifdef SOUND_PREEMPT_EN
  assign preempt = (pend_q != 4'b0000) && (sel > ev_q);
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ev_d     = ev_q;
    step_d   = step_q;
    frames_d = frames_q;
    done_d   = 1'b0;
    clr      = 4'b0000;
    case (state_q)
      IDLE: begin
        if (pend_q != 4'b0000) begin
          ev_d     = sel;
          step_d   = 2'd0;
          frames_d = step_dur(sel, 2'd0);
          clr      = 4'b0001 << sel;
          state_d  = PLAY;
        end
      end
      PLAY: begin
        if (snd.frame_pulse) begin
          if (preempt) begin
            ev_d     = sel;
            step_d   = 2'd0;
            frames_d = step_dur(sel, 2'd0);
            clr      = 4'b0001 << sel;
          end else if (frames_q == DUR_W'(1)) begin
            if (step_q == last_step(ev_q)) begin
              done_d   = 1'b1;
              state_d  = GAP;
              frames_d = DUR_W'(GAP_FRAMES);
            end else begin
              step_d   = step_q + 2'd1;
              frames_d = step_dur(ev_q, step_q + 2'd1);
            end
          end else begin
            frames_d = frames_q - DUR_W'(1);
          end
        end
      end
      GAP: begin
        if (snd.frame_pulse) begin
          if (frames_q <= DUR_W'(1)) begin
            state_d  = IDLE;
            frames_d = '0;
          end else begin
            frames_d = frames_q - DUR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new request in the same cycle as the clear keeps the bit set.
    pend_d = (pend_q & ~clr) | snd.ev_req;

    if (snd.mute) begin
      state_d  = IDLE;
      pend_d   = 4'b0000;
      done_d   = 1'b0;
      frames_d = '0;
    end

    {high_d, low_d} = (state_d == PLAY) ? step_tone(ev_d, step_d) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_q   <= 4'b0000;
      ev_q     <= 2'd0;
      step_q   <= 2'd0;
      frames_q <= '0;
      high_q   <= 1'b0;
      low_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      ev_q     <= ev_d;
      step_q   <= step_d;
      frames_q <= frames_d;
      high_q   <= high_d;
      low_q    <= low_d;
      done_q   <= done_d;
    end
  end

  assign snd.high_beep = high_q;
  assign snd.low_beep  = low_q;
  assign snd.busy      = (state_q != IDLE);
  assign snd.cur_ev    = ev_q;
  assign snd.done      = done_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// tb/tb_sound_sequencer.sv - directed self-checking bench for sound_sequencer.
module tb_sound_sequencer;
  logic clk;
  logic rst;
  int   total;
  int   passed;
  int   fails;
  int   done_cnt;
  int   d0;

  sound_sequencer_if s_if ();

  sound_sequencer dut (
    .clk (clk),
    .rst (rst),
    .snd (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (s_if.done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic fp, input logic [3:0] req);
    s_if.frame_pulse = fp;
    s_if.ev_req      = req;
    @(posedge clk);
    #1;
    s_if.frame_pulse = 1'b0;
    s_if.ev_req      = 4'b0000;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 4'b0000);
      cyc(1'b0, 4'b0000);
    end
  endtask

  initial begin
    total = 0; passed = 0; fails = 0; done_cnt = 0;
    rst = 1'b1;
    s_if.frame_pulse = 1'b0;
    s_if.ev_req      = 4'b0000;
    s_if.mute        = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_busy", s_if.busy, 1'b0);
    chk("rst_high", s_if.high_beep, 1'b0);
    chk("rst_low", s_if.low_beep, 1'b0);
    chk("rst_cur_ev", s_if.cur_ev, 2'd0);
    chk("rst_done", s_if.done, 1'b0);
    rst = 1'b0;
    cyc(1'b0, 4'b0000);

    // Single paddle request: low 3 then one gap frame.
    d0 = done_cnt;
    cyc(1'b0, 4'b0010);
    chk("t1_busy_t1", s_if.busy, 1'b0);
    cyc(1'b0, 4'b0000);
    chk("t1_busy_t2", s_if.busy, 1'b1);
    chk("t1_low_t2", s_if.low_beep, 1'b1);
    chk("t1_high_t2", s_if.high_beep, 1'b0);
    chk("t1_cur_ev", s_if.cur_ev, 2'd1);
    frames(2);
    chk("t1_low_f2", s_if.low_beep, 1'b1);
    cyc(1'b1, 4'b0000);
    chk("t1_low_f3", s_if.low_beep, 1'b0);
    chk("t1_done_f3", s_if.done, 1'b1);
    chk("t1_busy_gap", s_if.busy, 1'b1);
    cyc(1'b0, 4'b0000);
    chk("t1_done_drop", s_if.done, 1'b0);
    frames(1);
    chk("t1_busy_end", s_if.busy, 1'b0);
    chk("t1_done_cnt", done_cnt - d0, 1);

    // Simultaneous ev2 + ev0: brick first, then wall.
    d0 = done_cnt;
    cyc(1'b0, 4'b0101);
    cyc(1'b0, 4'b0000);
    chk("t2_cur_ev2", s_if.cur_ev, 2'd2);
    chk("t2_high_s0", s_if.high_beep, 1'b1);
    frames(2);
    chk("t2_low_s1", s_if.low_beep, 1'b1);
    chk("t2_high_s1", s_if.high_beep, 1'b0);
    frames(2);
    chk("t2_gap_low", s_if.low_beep, 1'b0);
    chk("t2_gap_busy", s_if.busy, 1'b1);
    frames(1);
    chk("t2_cur_ev0", s_if.cur_ev, 2'd0);
    chk("t2_high_ev0", s_if.high_beep, 1'b1);
    frames(2);
    frames(1);
    chk("t2_busy_end", s_if.busy, 1'b0);
    chk("t2_done_cnt", done_cnt - d0, 2);

    // Coalescing: three ev0 requests during ev3.
    d0 = done_cnt;
    cyc(1'b0, 4'b1000);
    cyc(1'b0, 4'b0000);
    chk("t3_cur_ev3", s_if.cur_ev, 2'd3);
    chk("t3_low_s0", s_if.low_beep, 1'b1);
    cyc(1'b0, 4'b0001);
    cyc(1'b0, 4'b0001);
    frames(4);
    chk("t3_off_low", s_if.low_beep, 1'b0);
    chk("t3_off_busy", s_if.busy, 1'b1);
    cyc(1'b0, 4'b0001);
    frames(2);
    chk("t3_low_s2", s_if.low_beep, 1'b1);
    frames(4);
    chk("t3_both", {s_if.high_beep, s_if.low_beep}, 2'b11);
    frames(8);
    chk("t3_gap", {s_if.high_beep, s_if.low_beep}, 2'b00);
    frames(1);
    chk("t3_ev0_cur", s_if.cur_ev, 2'd0);
    chk("t3_ev0_high", s_if.high_beep, 1'b1);
    frames(2);
    frames(1);
    cyc(1'b0, 4'b0000);
    chk("t3_busy_end", s_if.busy, 1'b0);
    chk("t3_done_cnt", done_cnt - d0, 2);

    // Mute during step 2 of ev3, with ev0 pending.
    d0 = done_cnt;
    cyc(1'b0, 4'b1000);
    cyc(1'b0, 4'b0000);
    frames(6);
    chk("t4_low_s2", s_if.low_beep, 1'b1);
    cyc(1'b0, 4'b0001);
    s_if.mute = 1'b1;
    cyc(1'b0, 4'b0000);
    chk("t4_mute_busy", s_if.busy, 1'b0);
    chk("t4_mute_out", {s_if.high_beep, s_if.low_beep}, 2'b00);
    cyc(1'b0, 4'b0100);
    cyc(1'b0, 4'b0000);
    s_if.mute = 1'b0;
    cyc(1'b0, 4'b0000);
    cyc(1'b0, 4'b0000);
    frames(1);
    chk("t4_unmute_busy", s_if.busy, 1'b0);
    chk("t4_done_cnt", done_cnt - d0, 0);

    // ev3 requested while ev1 plays.
    d0 = done_cnt;
    cyc(1'b0, 4'b0010);
    cyc(1'b0, 4'b0000);
    chk("t5_cur_ev1", s_if.cur_ev, 2'd1);
    cyc(1'b0, 4'b1000);
`ifdef SOUND_PREEMPT_EN
    cyc(1'b1, 4'b0000);
    chk("t5_pre_cur_ev", s_if.cur_ev, 2'd3);
    chk("t5_pre_low", s_if.low_beep, 1'b1);
    chk("t5_pre_done", s_if.done, 1'b0);
    cyc(1'b0, 4'b0000);
    frames(18);
    frames(1);
    chk("t5_pre_busy_end", s_if.busy, 1'b0);
    chk("t5_pre_done_cnt", done_cnt - d0, 1);
`else
    frames(2);
    cyc(1'b1, 4'b0000);
    chk("t5_ev1_done", s_if.done, 1'b1);
    chk("t5_ev1_cur", s_if.cur_ev, 2'd1);
    chk("t5_gap_low", s_if.low_beep, 1'b0);
    cyc(1'b0, 4'b0000);
    frames(1);
    chk("t5_ev3_cur", s_if.cur_ev, 2'd3);
    chk("t5_ev3_low", s_if.low_beep, 1'b1);
    frames(18);
    frames(1);
    chk("t5_busy_end", s_if.busy, 1'b0);
    chk("t5_done_cnt", done_cnt - d0, 2);
`endif

    // Reset pulse during PLAY.
    cyc(1'b0, 4'b0100);
    cyc(1'b0, 4'b0000);
    chk("t6_high_play", s_if.high_beep, 1'b1);
    rst = 1'b1;
    cyc(1'b0, 4'b0000);
    rst = 1'b0;
    chk("t6_busy", s_if.busy, 1'b0);
    chk("t6_out", {s_if.high_beep, s_if.low_beep}, 2'b00);
    chk("t6_cur_ev", s_if.cur_ev, 2'd0);
    chk("t6_done", s_if.done, 1'b0);
    frames(2);
    chk("t6_stay_idle", s_if.busy, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
